tomasulo_rs: RTL and testbench

Reservation-station bank for the Tomasulo issue path: the responder to the issue unit. It accepts one issued instruction per cycle, allocates a free entry, and returns that entry's tag for register-bank renaming. It snoops the CDB to resolve pending operands and dispatches ready operations to one functional unit. An entry is freed only when the CDB broadcasts its own tag.

---
 rtl/tomasulo_pkg.sv | 23 ++
 rtl/tomasulo_rs_if.sv | 32 +++
 rtl/rs_entry.sv | 60 ++++++
 rtl/tomasulo_rs.sv | 96 +++++++++
 tb/tb_tomasulo_rs.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg: widths, tag encoding and entry types shared by the reservation station.
package tomasulo_pkg;
    localparam int TAG_W = 5;
    localparam int OP_W = 5;
    localparam int RS_DATA_W = 32;
    localparam logic [TAG_W-1:0] INVALID_TAG = '1;

    typedef enum logic [1:0] {RS_FREE, RS_WAIT, RS_READY, RS_EXEC} rs_state_t;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [RS_DATA_W-1:0] val_1;
        logic [RS_DATA_W-1:0] val_2;
        logic [TAG_W-1:0] tag_1;
        logic [TAG_W-1:0] tag_2;
        rs_state_t state;
    } rs_entry_t;

    // A resolved operand never captures, even if the CDB carries the invalid tag.
    function automatic logic snoop_hit(logic cdb_valid, logic [TAG_W-1:0] cdb_tag, logic [TAG_W-1:0] tag);
        return cdb_valid && tag == cdb_tag && tag != INVALID_TAG;
    endfunction
endpackage

// File: rtl/tomasulo_rs_if.sv
// tomasulo_rs_if: issue, CDB and dispatch signals around the reservation station.
interface tomasulo_rs_if #(parameter int DATA_W = tomasulo_pkg::RS_DATA_W);
    import tomasulo_pkg::*;
    logic issue_valid;
    logic issue_ready;
    logic [OP_W-1:0] issue_op;
    logic [DATA_W-1:0] issue_val_1;
    logic [DATA_W-1:0] issue_val_2;
    logic [TAG_W-1:0] issue_tag_1;
    logic [TAG_W-1:0] issue_tag_2;
    logic [TAG_W-1:0] issue_tag;
    logic cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [DATA_W-1:0] cdb_val;
    logic disp_valid;
    logic disp_ready;
    logic [OP_W-1:0] disp_op;
    logic [DATA_W-1:0] disp_val_1;
    logic [DATA_W-1:0] disp_val_2;
    logic [TAG_W-1:0] disp_tag;

    modport master (
        output issue_valid, issue_op, issue_val_1, issue_val_2, issue_tag_1, issue_tag_2,
        output cdb_valid, cdb_tag, cdb_val, disp_ready,
        input issue_ready, issue_tag, disp_valid, disp_op, disp_val_1, disp_val_2, disp_tag
    );
    modport slave (
        input issue_valid, issue_op, issue_val_1, issue_val_2, issue_tag_1, issue_tag_2,
        input cdb_valid, cdb_tag, cdb_val, disp_ready,
        output issue_ready, issue_tag, disp_valid, disp_op, disp_val_1, disp_val_2, disp_tag
    );
endinterface

// File: rtl/rs_entry.sv
// rs_entry: one reservation-station slot; loads on allocation, snoops the CDB for
// pending operands, and frees itself when its own tag is broadcast while executing.
module rs_entry
    import tomasulo_pkg::*;
#(
    parameter logic [TAG_W-1:0] MY_TAG = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic pick,
    input  logic [OP_W-1:0] issue_op,
    input  logic [RS_DATA_W-1:0] issue_val_1,
    input  logic [RS_DATA_W-1:0] issue_val_2,
    input  logic [TAG_W-1:0] issue_tag_1,
    input  logic [TAG_W-1:0] issue_tag_2,
    input  logic cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [RS_DATA_W-1:0] cdb_val,
    output rs_state_t state,
    output logic [OP_W-1:0] op,
    output logic [RS_DATA_W-1:0] val_1,
    output logic [RS_DATA_W-1:0] val_2
);
    rs_entry_t entry_q, entry_d;
    logic snoop, hit_1, hit_2, resolved;
    logic [TAG_W-1:0] tag_1, tag_2;
    logic [RS_DATA_W-1:0] src_1, src_2;

    // A fresh load snoops the same cycle's CDB exactly like a waiting entry.
    always_comb begin
        snoop = load || entry_q.state == RS_WAIT;
        tag_1 = load ? issue_tag_1 : entry_q.tag_1;
        tag_2 = load ? issue_tag_2 : entry_q.tag_2;
        src_1 = load ? issue_val_1 : entry_q.val_1;
        src_2 = load ? issue_val_2 : entry_q.val_2;
        hit_1 = snoop && snoop_hit(cdb_valid, cdb_tag, tag_1);
        hit_2 = snoop && snoop_hit(cdb_valid, cdb_tag, tag_2);
        resolved = (hit_1 || tag_1 == INVALID_TAG) && (hit_2 || tag_2 == INVALID_TAG);
        entry_d.op = load ? issue_op : entry_q.op;
        entry_d.val_1 = hit_1 ? cdb_val : src_1;
        entry_d.val_2 = hit_2 ? cdb_val : src_2;
        entry_d.tag_1 = hit_1 ? INVALID_TAG : tag_1;
        entry_d.tag_2 = hit_2 ? INVALID_TAG : tag_2;
        entry_d.state = snoop ? (resolved ? RS_READY : RS_WAIT)
                      : (entry_q.state == RS_READY && pick) ? RS_EXEC
                      : (entry_q.state == RS_EXEC && cdb_valid && cdb_tag == MY_TAG) ? RS_FREE
                      : entry_q.state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) entry_q <= '0;
        else entry_q <= entry_d;
    end

    assign state = entry_q.state;
    assign op = entry_q.op;
    assign val_1 = entry_q.val_1;
    assign val_2 = entry_q.val_2;
endmodule

// File: rtl/tomasulo_rs.sv
// tomasulo_rs: reservation-station bank with lowest-free allocation, CDB snooping
// and a round-robin picker feeding a single dispatch register.
module tomasulo_rs
    import tomasulo_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_BASE = 0,
    parameter int DATA_W = RS_DATA_W
) (
    input logic clk,
    input logic rst_n,
    tomasulo_rs_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    rs_state_t st [NUM_ENTRIES];
    logic [OP_W-1:0] ent_op [NUM_ENTRIES];
    logic [RS_DATA_W-1:0] ent_val_1 [NUM_ENTRIES];
    logic [RS_DATA_W-1:0] ent_val_2 [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] load, pick;
    logic [IDX_W-1:0] alloc_idx, pick_idx, cand, rr_ptr_q, rr_ptr_d;
    logic any_free, found, disp_load, take;
    logic disp_valid_q, disp_valid_d;
    logic [OP_W-1:0] disp_op_q, disp_op_d;
    logic [DATA_W-1:0] disp_val_1_q, disp_val_1_d, disp_val_2_q, disp_val_2_d;
    logic [TAG_W-1:0] disp_tag_q, disp_tag_d;

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_ent
        rs_entry #(.MY_TAG(TAG_W'(TAG_BASE + g))) u_ent (
            .clk(clk), .rst_n(rst_n), .load(load[g]), .pick(pick[g]),
            .issue_op(bus.issue_op), .issue_val_1(bus.issue_val_1), .issue_val_2(bus.issue_val_2),
            .issue_tag_1(bus.issue_tag_1), .issue_tag_2(bus.issue_tag_2),
            .cdb_valid(bus.cdb_valid), .cdb_tag(bus.cdb_tag), .cdb_val(bus.cdb_val),
            .state(st[g]), .op(ent_op[g]), .val_1(ent_val_1[g]), .val_2(ent_val_2[g])
        );
    end

    // Descending scans so the lowest index (or nearest to rr_ptr) wins.
    always_comb begin
        any_free = 1'b0;
        alloc_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--)
            if (st[i] == RS_FREE) begin
                any_free = 1'b1;
                alloc_idx = IDX_W'(i);
            end
        found = 1'b0;
        pick_idx = '0;
        cand = '0;
        for (int k = NUM_ENTRIES - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_ENTRIES);
            if (st[cand] == RS_READY) begin
                found = 1'b1;
                pick_idx = cand;
            end
        end
        disp_load = !disp_valid_q || bus.disp_ready;
        take = disp_load && found;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            load[i] = bus.issue_valid && any_free && alloc_idx == IDX_W'(i);
            pick[i] = take && pick_idx == IDX_W'(i);
        end
        rr_ptr_d = take ? IDX_W'((int'(pick_idx) + 1) % NUM_ENTRIES) : rr_ptr_q;
        disp_valid_d = disp_load ? found : disp_valid_q;
        disp_op_d = take ? ent_op[pick_idx] : disp_op_q;
        disp_val_1_d = take ? ent_val_1[pick_idx] : disp_val_1_q;
        disp_val_2_d = take ? ent_val_2[pick_idx] : disp_val_2_q;
        disp_tag_d = take ? TAG_W'(TAG_BASE + int'(pick_idx)) : disp_tag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            disp_valid_q <= 1'b0;
            disp_op_q <= '0;
            disp_val_1_q <= '0;
            disp_val_2_q <= '0;
            disp_tag_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            disp_valid_q <= disp_valid_d;
            disp_op_q <= disp_op_d;
            disp_val_1_q <= disp_val_1_d;
            disp_val_2_q <= disp_val_2_d;
            disp_tag_q <= disp_tag_d;
        end
    end

    assign bus.issue_ready = any_free;
    assign bus.issue_tag = any_free ? TAG_W'(TAG_BASE + int'(alloc_idx)) : '0;
    assign bus.disp_valid = disp_valid_q;
    assign bus.disp_op = disp_op_q;
    assign bus.disp_val_1 = disp_val_1_q;
    assign bus.disp_val_2 = disp_val_2_q;
    assign bus.disp_tag = disp_tag_q;
endmodule

// File: tb/tb_tomasulo_rs.sv
// tb_tomasulo_rs: directed and random stimulus; a transaction-level model predicts
// each dispatch into a queue that a negedge monitor drains and compares.
module tb_tomasulo_rs;
    localparam int N = 4;
    localparam int TB = 0;
    localparam logic [4:0] INV = 5'h1f;
    localparam int FREE = 0, WAITING = 1, RDY = 2, EXEC = 3;

    typedef struct {
        logic [4:0] tag;
        logic [4:0] op;
        logic [31:0] v1;
        logic [31:0] v2;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    int m_st [N];
    logic [4:0] m_op [N];
    logic [4:0] m_t1 [N];
    logic [4:0] m_t2 [N];
    logic [31:0] m_v1 [N];
    logic [31:0] m_v2 [N];
    int m_rr;
    bit m_dv;
    exp_t exp_q [$];

    always #5 clk = ~clk;

    tomasulo_rs_if #(.DATA_W(32)) bus ();
    tomasulo_rs #(.NUM_ENTRIES(N), .TAG_BASE(TB), .DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest_free();
        for (int i = 0; i < N; i++) if (m_st[i] == FREE) return i;
        return -1;
    endfunction

    task automatic resolve(input int i);
        if (bus.cdb_valid && m_t1[i] != INV && m_t1[i] == bus.cdb_tag) begin
            m_v1[i] = bus.cdb_val;
            m_t1[i] = INV;
        end
        if (bus.cdb_valid && m_t2[i] != INV && m_t2[i] == bus.cdb_tag) begin
            m_v2[i] = bus.cdb_val;
            m_t2[i] = INV;
        end
        m_st[i] = (m_t1[i] == INV && m_t2[i] == INV) ? RDY : WAITING;
    endtask

    task automatic model_step();
        int ost [N];
        int pick = -1;
        int alloc = -1;
        bit ld = !m_dv || bus.disp_ready;
        for (int i = 0; i < N; i++) ost[i] = m_st[i];
        if (ld) for (int k = 0; k < N; k++) if (pick < 0 && ost[(m_rr + k) % N] == RDY) pick = (m_rr + k) % N;
        if (bus.issue_valid) for (int i = N - 1; i >= 0; i--) if (ost[i] == FREE) alloc = i;
        for (int i = 0; i < N; i++) begin
            if (ost[i] == EXEC && bus.cdb_valid && bus.cdb_tag == 5'(TB + i)) m_st[i] = FREE;
            if (ost[i] == WAITING) resolve(i);
        end
        if (alloc >= 0) begin
            m_op[alloc] = bus.issue_op;
            m_v1[alloc] = bus.issue_val_1;
            m_v2[alloc] = bus.issue_val_2;
            m_t1[alloc] = bus.issue_tag_1;
            m_t2[alloc] = bus.issue_tag_2;
            resolve(alloc);
        end
        if (ld) begin
            m_dv = pick >= 0;
            if (pick >= 0) begin
                exp_q.push_back('{5'(TB + pick), m_op[pick], m_v1[pick], m_v2[pick]});
                m_st[pick] = EXEC;
                m_rr = (pick + 1) % N;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) m_st[i] = FREE;
            m_rr = 0;
            m_dv = 1'b0;
            exp_q.delete();
        end else model_step();
    end

    // Monitor: compares registered outputs mid-cycle, pops on each dispatch handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            int lf;
            lf = lowest_free();
            chk("issue_ready", bus.issue_ready, lf >= 0);
            chk("issue_tag", bus.issue_tag, lf >= 0 ? TB + lf : 0);
            chk("disp_valid", bus.disp_valid, exp_q.size() != 0);
            if (bus.disp_valid && exp_q.size() != 0) begin
                chk("disp_tag", bus.disp_tag, exp_q[0].tag);
                chk("disp_op", bus.disp_op, exp_q[0].op);
                chk("disp_val_1", bus.disp_val_1, exp_q[0].v1);
                chk("disp_val_2", bus.disp_val_2, exp_q[0].v2);
                if (bus.disp_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive(input bit iv, input int op, input int v1, input int t1, input int v2, input int t2,
                         input bit cv, input int ct, input int cval, input bit dr);
        @(posedge clk);
        #1;
        bus.issue_valid = iv;
        bus.issue_op = 5'(op);
        bus.issue_val_1 = 32'(v1);
        bus.issue_tag_1 = 5'(t1);
        bus.issue_val_2 = 32'(v2);
        bus.issue_tag_2 = 5'(t2);
        bus.cdb_valid = cv;
        bus.cdb_tag = 5'(ct);
        bus.cdb_val = 32'(cval);
        bus.disp_ready = dr;
    endtask

    task automatic idle(input bit dr);
        drive(0, 0, 0, 31, 0, 31, 0, 0, 0, dr);
    endtask

    task automatic bcast(input int ct, input int cval);
        drive(0, 0, 0, 31, 0, 31, 1, ct, cval, 1);
    endtask

    task automatic issue(input int op, input int v1, input int t1, input int v2, input int t2, input bit dr);
        drive(1, op, v1, t1, v2, t2, 0, 0, 0, dr);
    endtask

    function automatic int rtag();
        int r = $urandom_range(0, 3);
        return r < 2 ? 31 : r == 2 ? $urandom_range(0, 3) : $urandom_range(8, 11);
    endfunction

    initial begin
        bus.issue_valid = 0; bus.issue_op = 0; bus.issue_val_1 = 0; bus.issue_val_2 = 0;
        bus.issue_tag_1 = INV; bus.issue_tag_2 = INV; bus.cdb_valid = 0; bus.cdb_tag = 0;
        bus.cdb_val = 0; bus.disp_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_disp_valid", bus.disp_valid, 0);
        chk("rst_disp_op", bus.disp_op, 0);
        chk("rst_disp_val_1", bus.disp_val_1, 0);
        chk("rst_disp_val_2", bus.disp_val_2, 0);
        chk("rst_disp_tag", bus.disp_tag, 0);
        rst_n = 1'b1;
        idle(1);
        chk("rst_issue_ready", bus.issue_ready, 1);
        chk("rst_issue_tag", bus.issue_tag, TB);

        // Both operands present: dispatch two cycles after issue, freed by own tag.
        issue(3, 10, 31, 20, 31, 1);
        idle(1);
        chk("t2_not_yet", bus.disp_valid, 0);
        idle(1);
        chk("t2_valid", bus.disp_valid, 1);
        chk("t2_op", bus.disp_op, 3);
        chk("t2_v1", bus.disp_val_1, 10);
        chk("t2_v2", bus.disp_val_2, 20);
        chk("t2_tag", bus.disp_tag, 0);
        bcast(0, 32'h99);
        chk("t2_busy_tag", bus.issue_tag, 1);
        idle(1);
        chk("t2_freed_tag", bus.issue_tag, 0);

        // Pending operand resolved by a later CDB broadcast.
        issue(5, 0, 7, 2, 31, 1);
        idle(1);
        bcast(7, 32'h55);
        idle(1);
        chk("t3_not_yet", bus.disp_valid, 0);
        idle(1);
        chk("t3_valid", bus.disp_valid, 1);
        chk("t3_v1", bus.disp_val_1, 32'h55);
        chk("t3_v2", bus.disp_val_2, 2);
        bcast(0, 0);
        idle(1);

        // Operand captured from a CDB broadcast in the issue cycle.
        drive(1, 7, 1, 31, 0, 9, 1, 9, 32'hAA, 1);
        idle(1);
        chk("t4_not_yet", bus.disp_valid, 0);
        idle(1);
        chk("t4_valid", bus.disp_valid, 1);
        chk("t4_v2", bus.disp_val_2, 32'hAA);
        chk("t4_v1", bus.disp_val_1, 1);
        bcast(0, 0);
        idle(1);

        // Fill all entries; a fifth issue is ignored; own tag 2 frees entry 2.
        for (int i = 1; i <= 4; i++) issue(i, i, 31, i * 2, 31, 1);
        issue(9, 9, 31, 9, 31, 1);
        chk("t5_full", bus.issue_ready, 0);
        chk("t5_full_tag", bus.issue_tag, 0);
        idle(1);
        chk("t5_still_full", bus.issue_ready, 0);
        idle(1);
        bcast(2, 0);
        idle(1);
        chk("t5_freed", bus.issue_ready, 1);
        chk("t5_freed_tag", bus.issue_tag, 2);
        bcast(0, 0);
        bcast(1, 0);
        bcast(3, 0);
        idle(1);

        // Stalled dispatch holds entry 0; then round-robin gives entry 1.
        issue(9, 100, 31, 101, 31, 0);
        issue(10, 200, 31, 201, 31, 0);
        idle(0);
        chk("t6_hold0", bus.disp_tag, 0);
        idle(0);
        chk("t6_hold1", bus.disp_tag, 0);
        chk("t6_hold1_op", bus.disp_op, 9);
        idle(1);
        chk("t6_hold2", bus.disp_tag, 0);
        idle(1);
        chk("t6_next", bus.disp_tag, 1);
        chk("t6_next_op", bus.disp_op, 10);
        bcast(0, 0);
        bcast(1, 0);
        idle(1);

        // Reset mid-operation discards entries and the dispatch register.
        issue(11, 5, 31, 6, 31, 0);
        issue(12, 7, 20, 8, 31, 0);
        idle(0);
        idle(0);
        chk("t7_pre_valid", bus.disp_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_valid", bus.disp_valid, 0);
        chk("t7_rst_tag", bus.disp_tag, 0);
        chk("t7_rst_ready", bus.issue_ready, 1);
        chk("t7_rst_itag", bus.issue_tag, 0);
        idle(1);
        rst_n = 1'b1;
        idle(1);

        for (int n = 0; n < 3000; n++)
            drive(1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom, rtag(), $urandom, rtag(),
                  1'($urandom_range(0, 1)), $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(8, 11),
                  $urandom, $urandom_range(0, 9) < 7);
        repeat (4) idle(1);
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
